// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 LCD driver.
// Holds the FSM state encoding, instruction bytes and the power-up init table.
package lcd_pkg;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_LOAD,
        S_SETUP,
        S_EHI,
        S_WAIT,
        S_IDLE
    } lcd_state_t;

    localparam logic [7:0] LCD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_HOME  = 8'h02;
    localparam logic [7:0] LCD_HOME2 = 8'h03;
    localparam logic [7:0] LCD_LINE1 = 8'h80;
    localparam logic [7:0] LCD_LINE2 = 8'hC0;

    localparam int         INIT_LEN  = 7;
    localparam logic [2:0] INIT_LAST = 3'(INIT_LEN - 1);

    // Wake-up x3, 8-bit/2-line, display on, clear, entry increment.
    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h30;
            3'd1:    b = 8'h30;
            3'd2:    b = 8'h30;
            3'd3:    b = 8'h38;
            3'd4:    b = 8'h0C;
            3'd5:    b = LCD_CLEAR;
            3'd6:    b = 8'h06;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lcd_hd44780_driver_if.sv
// Upstream write port of the LCD driver.
// The producer drives en/cmd/data and honours busy.
interface lcd_hd44780_driver_if;
    logic       en;
    logic       cmd;
    logic [7:0] data;
    logic       busy;

    modport master (
        output en,
        output cmd,
        output data,
        input  busy
    );

    modport slave (
        input  en,
        input  cmd,
        input  data,
        output busy
    );
endinterface

// File: rtl/lcd_cmd_fifo.sv
// Small synchronous FIFO buffering {cmd,data} entries.
// Head is read combinationally; push when full and pop when empty are ignored.
module lcd_cmd_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 9,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);
    localparam logic [AW:0] FULL_N = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign empty   = (count == '0);
    assign full    = (count == FULL_N);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/lcd_hd44780_driver.sv
// HD44780 write-only driver: runs the init sequence, then replays
// buffered {cmd,data} entries as timed 8-bit bus cycles.
module lcd_hd44780_driver
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter int PWRUP_CYC     = 750000,
    parameter int SETUP_CYC     = 3,
    parameter int E_HI_CYC      = 12,
    parameter int WAIT_CYC      = 2000,
    parameter int WAIT_LONG_CYC = 82000,
    parameter int WAKE_CYC      = 205000
) (
    input  logic                 clk,
    input  logic                 rst,
    lcd_hd44780_driver_if.slave  up,
    output logic                 overflow,
    output logic                 lcd_rs,
    output logic                 lcd_rw,
    output logic                 lcd_e,
    output logic [7:0]           lcd_db
);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int MAX_A   = PWRUP_CYC > WAKE_CYC ? PWRUP_CYC : WAKE_CYC;
    localparam int CNT_MAX = MAX_A > WAIT_LONG_CYC ? MAX_A : WAIT_LONG_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] PWRUP_END = CW'(PWRUP_CYC - 1);
    localparam logic [CW-1:0] SETUP_END = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EHI_END   = CW'(E_HI_CYC - 1);
    localparam logic [CW-1:0] WAIT_END  = CW'(WAIT_CYC - 1);
    localparam logic [CW-1:0] LONG_END  = CW'(WAIT_LONG_CYC - 1);
    localparam logic [CW-1:0] WAKE_END  = CW'(WAKE_CYC - 1);
    localparam logic [AW:0]   BUSY_THR  = (AW + 1)'(FIFO_DEPTH - 3);

    lcd_state_t    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    init_idx, idx_n;
    logic          init_done, done_n;
    logic          rs_n, e_n;
    logic [7:0]    db_n;
    logic          pop;
    logic [8:0]    head;
    logic          empty, full;
    logic [AW:0]   count;
    logic          long_cmd;
    logic [CW-1:0] wait_end;

    lcd_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (up.en),
        .pop   (pop),
        .din   ({up.cmd, up.data}),
        .dout  (head),
        .empty (empty),
        .full  (full),
        .count (count)
    );

    // Keep three free slots so a multi-write burst never overruns.
    assign up.busy = ~init_done | (count > BUSY_THR);
    assign lcd_rw  = 1'b0;

    assign long_cmd = ~lcd_rs & (lcd_db == LCD_CLEAR ||
                                 lcd_db == LCD_HOME  ||
                                 lcd_db == LCD_HOME2);

    always_comb begin
        wait_end = WAIT_END;
        if (!init_done && init_idx == '0) wait_end = WAKE_END;
        else if (long_cmd)                wait_end = LONG_END;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = init_idx;
        done_n  = init_done;
        rs_n    = lcd_rs;
        db_n    = lcd_db;
        e_n     = 1'b0;
        pop     = 1'b0;
        case (state)
            S_PWRUP: begin
                if (cnt == PWRUP_END) begin
                    state_n = S_LOAD;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
            end
            S_LOAD: begin
                state_n = S_SETUP;
                cnt_n   = '0;
                if (init_done) begin
                    rs_n = ~head[8];
                    db_n = head[7:0];
                    pop  = 1'b1;
                end else begin
                    rs_n = 1'b0;
                    db_n = init_byte(init_idx);
                end
            end
            S_SETUP: begin
                if (cnt == SETUP_END) begin
                    state_n = S_EHI;
                    cnt_n   = '0;
                    e_n     = 1'b1;
                end
            end
            S_EHI: begin
                e_n = 1'b1;
                if (cnt == EHI_END) begin
                    state_n = S_WAIT;
                    cnt_n   = '0;
                    e_n     = 1'b0;
                end
            end
            S_WAIT: begin
                if (cnt == wait_end) begin
                    cnt_n = '0;
                    if (init_done) begin
                        state_n = S_IDLE;
                    end else if (init_idx == INIT_LAST) begin
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        idx_n   = init_idx + 1'b1;
                        state_n = S_LOAD;
                    end
                end
            end
            S_IDLE: begin
                cnt_n = '0;
                if (!empty) state_n = S_LOAD;
            end
            default: begin
                state_n = S_PWRUP;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_PWRUP;
            cnt       <= '0;
            init_idx  <= '0;
            init_done <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_db    <= 8'h00;
            lcd_e     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            init_idx  <= idx_n;
            init_done <= done_n;
            lcd_rs    <= rs_n;
            lcd_db    <= db_n;
            lcd_e     <= e_n;
            if (up.en && full) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_hd44780_driver.sv
// Scoreboard bench for lcd_hd44780_driver: expected LCD writes are queued
// as stimulus is driven and matched against each rising edge of lcd_e.
module tb_lcd_hd44780_driver;

    localparam int PWRUP = 100;
    localparam int SETUP = 2;
    localparam int E_HI  = 4;
    localparam int WAIT  = 20;
    localparam int WLONG = 50;
    localparam int WAKE  = 40;
    localparam int DEPTH = 8;
    // E-low cycles between pulses beyond the wait itself
    localparam int GAP_INIT = 1 + SETUP;
    localparam int GAP_RUN  = 2 + SETUP;

    typedef struct {
        logic       rs;
        logic [7:0] db;
        int         gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       overflow;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_db;

    lcd_hd44780_driver_if bus();

    exp_t       sb [$];
    exp_t       ex;
    int         checks = 0;
    int         errors = 0;
    int         hi_cnt = 0;
    int         lo_cnt = 0;
    int         idle_run = 0;
    logic       prev_e = 1'b0;
    logic [7:0] init_db [7] = '{8'h30, 8'h30, 8'h30, 8'h38,
                                8'h0C, 8'h01, 8'h06};

    lcd_hd44780_driver #(
        .FIFO_DEPTH    (DEPTH),
        .PWRUP_CYC     (PWRUP),
        .SETUP_CYC     (SETUP),
        .E_HI_CYC      (E_HI),
        .WAIT_CYC      (WAIT),
        .WAIT_LONG_CYC (WLONG),
        .WAKE_CYC      (WAKE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .up       (bus),
        .overflow (overflow),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_e    (lcd_e),
        .lcd_db   (lcd_db)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            prev_e   = 1'b0;
            hi_cnt   = 0;
            lo_cnt   = 0;
            idle_run = 0;
        end else begin
            if (lcd_e && !prev_e) begin
                chk("sb_ready", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    ex = sb.pop_front();
                    chk("pulse_rs", lcd_rs, ex.rs);
                    chk("pulse_db", lcd_db, ex.db);
                    chk("pulse_rw", lcd_rw, 0);
                    if (ex.gap >= 0) chk("gap", lo_cnt, ex.gap);
                end
                hi_cnt = 0;
            end
            if (!lcd_e && prev_e) begin
                chk("e_width", hi_cnt, E_HI);
                lo_cnt = 0;
            end
            if (lcd_e) hi_cnt++;
            else       lo_cnt++;
            idle_run = lcd_e ? 0 : idle_run + 1;
            prev_e   = lcd_e;
        end
    end

    task automatic load_init();
        int g;
        for (int i = 0; i < 7; i++) begin
            g = WAIT + GAP_INIT;
            if (i == 0) g = -1;
            if (i == 1) g = WAKE + GAP_INIT;
            if (i == 6) g = WLONG + GAP_INIT;
            sb.push_back('{rs: 1'b0, db: init_db[i], gap: g});
        end
    endtask

    // Called on a negedge; en is sampled by the following posedge.
    task automatic send(input logic c, input logic [7:0] d,
                        input int gap, input bit keep);
        bus.en   = 1'b1;
        bus.cmd  = c;
        bus.data = d;
        if (keep) sb.push_back('{rs: ~c, db: d, gap: gap});
        @(negedge clk);
        bus.en = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (!(sb.size() == 0 && idle_run >= 60) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n < 5000, 1);
    endtask

    task automatic wait_e_high(input string tag);
        int n = 0;
        while (!lcd_e && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(tag, lcd_e, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.en   = 1'b0;
        bus.cmd  = 1'b0;
        bus.data = 8'h00;

        // 1: reset state and init sequence
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 1);
        chk("rst_ovf", overflow, 0);
        chk("rst_e", lcd_e, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_rw", lcd_rw, 0);
        chk("rst_db", lcd_db, 8'h00);
        load_init();
        rst = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("init_pulses", sb.size(), 0);
        chk("init_busy_hi", bus.busy, 1);
        n = 0;
        while (lcd_e && n < 50) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("busy_fall", n, WAIT);
        drain("drain_init");

        // 2: single character latency
        send(1'b0, 8'h41, -1, 1'b1);
        @(negedge clk);
        chk("lat_early_rs", lcd_rs, 0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("lat_rs", lcd_rs, 1);
                chk("lat_db", lcd_db, 8'h41);
            end
            chk("lat_e", lcd_e, (i >= 2 && i <= 5));
            chk("lat_busy", bus.busy, 0);
        end
        drain("drain_lat");

        // 3: back-to-back burst
        send(1'b1, 8'hC5, -1, 1'b1);
        send(1'b0, 8'h20, WAIT + GAP_RUN, 1'b1);
        send(1'b1, 8'hC5, WAIT + GAP_RUN, 1'b1);
        drain("drain_burst");
        chk("burst_ovf", overflow, 0);

        // 4: fill past capacity while a clear is in its long wait
        send(1'b1, 8'h01, -1, 1'b1);
        wait_e_high("fill_e");
        for (int i = 1; i <= 9; i++) begin
            send(1'b0, 8'h50 + 8'(i),
                 (i == 1) ? WLONG + GAP_RUN : WAIT + GAP_RUN, i <= DEPTH);
            chk("fill_busy", bus.busy, (i > 5));
            chk("fill_ovf", overflow, (i == 9));
        end
        drain("drain_fill");
        chk("ovf_sticky", overflow, 1);
        chk("fill_busy_end", bus.busy, 0);

        // 5: clear vs. character 01h wait lengths
        send(1'b1, 8'h01, -1, 1'b1);
        send(1'b0, 8'h01, WLONG + GAP_RUN, 1'b1);
        send(1'b0, 8'h41, WAIT + GAP_RUN, 1'b1);
        drain("drain_wait");

        // 6: reset mid-pulse with entries buffered
        send(1'b1, 8'h01, -1, 1'b1);
        wait_e_high("rst_mid_e");
        send(1'b0, 8'h61, -1, 1'b1);
        send(1'b0, 8'h62, -1, 1'b1);
        chk("pre_rst_e", lcd_e, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_e", lcd_e, 0);
        chk("mid_rst_busy", bus.busy, 1);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_db", lcd_db, 8'h00);
        sb.delete();
        repeat (3) @(negedge clk);
        chk("hold_rst_e", lcd_e, 0);
        load_init();
        rst = 1'b1;
        drain("drain_reinit");
        repeat (100) @(negedge clk);
        chk("final_sb", sb.size(), 0);
        chk("final_busy", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
